// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle for div_unit.
//   start_i, op_i, data1_i, data2_i : request side, driven by the master
//   data_o, busy_o, done_o, Zero_o  : result side, driven by the divider
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;
    logic             done_o;
    logic             Zero_o;

    modport master(output start_i, op_i, data1_i, data2_i, input data_o, busy_o, done_o, Zero_o);
    modport slave(input start_i, op_i, data1_i, data2_i, output data_o, busy_o, done_o, Zero_o);
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active low
//   bus    : div_unit_if slave (start/op/operands in, result/busy/done/zero out)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;

    logic             signed_op, a_neg, b_neg, div0, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, byp_res;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx, calc_res;

    always_comb begin
        signed_op = ~bus.op_i[0];
        a_neg     = signed_op & bus.data1_i[WIDTH-1];
        b_neg     = signed_op & bus.data2_i[WIDTH-1];
        a_mag     = a_neg ? -bus.data1_i : bus.data1_i;
        b_mag     = b_neg ? -bus.data2_i : bus.data2_i;
        div0      = bus.data2_i == '0;
        ovf       = signed_op && bus.data1_i == {1'b1, {(WIDTH-1){1'b0}}} && bus.data2_i == '1;
        // Overflow quotient equals the dividend itself (0x80000000)
        byp_res   = div0 ? (bus.op_i[1] ? bus.data1_i : '1) : (bus.op_i[1] ? '0 : bus.data1_i);
        // Partial remainder never reaches the divisor, so only the shifted value needs the extra bit
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        ge        = rem_sh >= {1'b0, dvs_q};
        rem_nx    = ge ? rem_sh[WIDTH-1:0] - dvs_q : rem_sh[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], ge};
        calc_res  = is_rem_q ? (rneg_q ? -rem_nx : rem_nx) : (qneg_q ? -quo_nx : quo_nx);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        data_d   = data_q;
        zero_d   = zero_q;
        if (state_q == CALC) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(WIDTH-1)) begin
                state_d = DONE;
                data_d  = calc_res;
                zero_d  = calc_res == '0;
            end
        end else begin
            state_d = IDLE;
            if (bus.start_i) begin
                is_rem_d = bus.op_i[1];
                if (div0 || ovf) begin
                    state_d = DONE;
                    data_d  = byp_res;
                    zero_d  = byp_res == '0;
                end else begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.data_o = data_q;
    assign bus.Zero_o = zero_q;
    assign bus.busy_o = state_q == CALC;
    assign bus.done_o = state_q == DONE;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand and result width; only 32 is required to be supported.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request; sampled on a rising edge of clk_i.
REQ-005 op_i  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 data1_i  input  WIDTH  dividend.
REQ-007 data2_i  input  WIDTH  divisor.
REQ-008 data_o  output  WIDTH  result, registered.
REQ-009 busy_o  output  1  high while the iteration is in progress.
REQ-010 done_o  output  1  single-cycle pulse; data_o is valid in this cycle.
REQ-011 Zero_o  output  1  high when data_o == 0, registered together with data_o.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 A start_i sampled high in IDLE or DONE SHALL be accepted and SHALL latch op_i, data1_i and data2_i; later changes on those inputs SHALL have no effect until the next accept.
REQ-014 A start_i sampled high in CALC SHALL be ignored: no queueing, no error indication.
REQ-015 Normal path: accept at edge k, CALC during cycles k+1..k+32 with one quotient bit per cycle (radix-2 restoring, 6-bit iteration counter), DONE in cycle k+33 with done_o=1, then IDLE, unless a new start is accepted in DONE.
REQ-016 busy_o SHALL be 1 exactly while the state is CALC.
REQ-017 Signed ops (DIV, REM) SHALL iterate on operand magnitudes.
  - The quotient SHALL be negated when the operand signs differ.
  - The remainder SHALL take the sign of the dividend.
  - Results SHALL satisfy dividend = quotient*divisor + remainder, truncating toward zero.
REQ-018 Divide by zero (latched divisor == 0) SHALL bypass CALC and go IDLE/DONE -> DONE, with done_o in cycle k+1.
  - DIV and DIVU SHALL return 0xFFFFFFFF.
  - REM and REMU SHALL return the dividend.
REQ-019 Signed overflow (DIV or REM with dividend 0x80000000 and divisor 0xFFFFFFFF) SHALL take the same 1-cycle bypass.
  - DIV SHALL return 0x80000000.
  - REM SHALL return 0.
REQ-020 data_o and Zero_o SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-021 done_o SHALL never assert in the same cycle as busy_o.
REQ-022 Back-to-back: accept in DONE at edge j SHALL give busy_o=1 from cycle j+1 (normal path) or done_o=1 again in cycle j+1 (bypass).
REQ-023 DIVU and REMU SHALL treat both operands as unsigned; no overflow case exists for them.

Reset
REQ-024 rst_i low SHALL immediately force: state IDLE, busy_o=0, done_o=0, data_o=0, Zero_o=1, iteration counter 0.
REQ-025 Reset asserted during CALC SHALL abort the operation with no done_o pulse.
REQ-026 After rst_i deasserts, the first start_i SHALL be accepted on the first rising edge.

Verification
REQ-027 DIV 100/7, start at edge k -> busy_o high for cycles k+1..k+32; done_o=1 at k+33; data_o=0x0000000E; Zero_o=0.
REQ-028 DIV -7/2 -> data_o=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 0x00000001.
REQ-029 DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0x80000000/3 -> 0x00000002; REMU 6/3 -> 0, Zero_o=1.
REQ-030 DIV 5/0 -> done_o at k+1, data_o=0xFFFFFFFF, busy_o never high; REM 5/0 -> 0x00000005.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> done_o at k+1, data_o=0x80000000; REM of the same operands -> 0.
REQ-032 Accept DIVU 50/5 and pulse start_i with other operands at k+5 -> ignored, result 0x0000000A.
  - Then assert rst_i low at k+10 of a new operation -> busy_o=0, data_o=0 at once, no done_o.
  - After release, DIV 9/3 -> 0x00000003.
